// File: rtl/fwd_scoreboard.sv
// Forwarding and load-use hazard unit for a multi-issue pipeline.
// Tracks in-flight destination writes after E and returns per-operand bypass selects and a load-use stall.
module fwd_scoreboard #(
    parameter int unsigned LANES    = 2,
    parameter int unsigned STAGES   = 2,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned SEL_W    = $clog2(LANES*STAGES+1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [LANES-1:0]          ex_valid_i,
    input  logic [LANES-1:0]          ex_regwrite_i,
    input  logic [LANES-1:0]          ex_is_load_i,
    input  logic [5*LANES-1:0]        ex_dest_i,
    input  logic [10*LANES-1:0]       ex_src_i,
    input  logic [2*LANES-1:0]        ex_src_used_i,
    input  logic                      flush_i,
    output logic [SEL_W*2*LANES-1:0]  fwd_sel_o,
    output logic                      stall_o,
    output logic [15:0]               stall_cycles_o
);

    localparam int unsigned REG_W = 5;
    localparam int unsigned OPS   = 2 * LANES;
    localparam int unsigned CNT_W = 16;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dest;
        logic             is_load;
    } entry_t;

    entry_t [STAGES-1:0][LANES-1:0] sb_q, sb_d;
    logic   [CNT_W-1:0]             cnt_q, cnt_d;
    logic                           stall_c;
    logic   [REG_W-1:0]             src_c;
    logic   [SEL_W-1:0]             sel_c;
    logic                           load_c;

    // Operand lookup: scan oldest to youngest so the youngest (lowest stage, lowest lane) match wins.
    always_comb begin
        fwd_sel_o = '0;
        stall_c   = 1'b0;
        src_c     = '0;
        sel_c     = '0;
        load_c    = 1'b0;
        for (int unsigned k = 0; k < OPS; k++) begin
            src_c  = ex_src_i[REG_W*k +: REG_W];
            sel_c  = '0;
            load_c = 1'b0;
            for (int s = int'(STAGES) - 1; s >= 0; s--) begin
                for (int l = int'(LANES) - 1; l >= 0; l--) begin
                    if (sb_q[s][l].valid && (sb_q[s][l].dest == src_c) && (src_c != '0)) begin
                        sel_c  = SEL_W'(1 + s * int'(LANES) + l);
                        load_c = sb_q[s][l].is_load && (s < int'(LOAD_LAT));
                    end
                end
            end
            fwd_sel_o[SEL_W*k +: SEL_W] = sel_c;
            if (load_c && ex_src_used_i[k] && ex_valid_i[k/2]) begin
                stall_c = 1'b1;
            end
        end
    end

    assign stall_o        = stall_c;
    assign stall_cycles_o = cnt_q;

    // Shift the scoreboard; a stalled or flushed bundle enters as a bubble.
    always_comb begin
        sb_d = sb_q;
        for (int s = int'(STAGES) - 1; s >= 1; s--) begin
            sb_d[s] = sb_q[s-1];
        end
        for (int unsigned l = 0; l < LANES; l++) begin
            if (stall_c || flush_i) begin
                sb_d[0][l] = '0;
            end else begin
                sb_d[0][l].valid   = ex_valid_i[l] && ex_regwrite_i[l] &&
                                     (ex_dest_i[REG_W*l +: REG_W] != '0);
                sb_d[0][l].dest    = ex_dest_i[REG_W*l +: REG_W];
                sb_d[0][l].is_load = ex_is_load_i[l];
            end
        end
        cnt_d = cnt_q;
        if (stall_c && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q  <= '0;
            cnt_q <= '0;
        end else begin
            sb_q  <= sb_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Scoreboard bench for fwd_scoreboard: directed stimulus pushes expectations, a negedge monitor checks them.
module tb_fwd_scoreboard;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  ex_valid, ex_regwrite, ex_is_load;
    logic [9:0]  ex_dest;
    logic [19:0] ex_src;
    logic [3:0]  ex_src_used;
    logic        flush;
    logic [11:0] fwd_sel;
    logic        stall;
    logic [15:0] stall_cycles;

    fwd_scoreboard #(.LANES(2), .STAGES(2), .LOAD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid_i(ex_valid), .ex_regwrite_i(ex_regwrite), .ex_is_load_i(ex_is_load),
        .ex_dest_i(ex_dest), .ex_src_i(ex_src), .ex_src_used_i(ex_src_used), .flush_i(flush),
        .fwd_sel_o(fwd_sel), .stall_o(stall), .stall_cycles_o(stall_cycles)
    );

    // Deep-load instance: a load re-issues every 8 cycles and stalls 7 of them, driving the counter to saturation.
    logic        rst_sat_n = 1'b0;
    logic [0:0]  s_one = 1'b1;
    logic [4:0]  s_dest = 5'd9;
    logic [9:0]  s_src = {5'd0, 5'd9};
    logic [1:0]  s_used = 2'b01;
    logic [7:0]  s_fwd_sel;
    logic        s_stall;
    logic [15:0] s_cnt;

    fwd_scoreboard #(.LANES(1), .STAGES(8), .LOAD_LAT(7)) dut_sat (
        .clk(clk), .rst_n(rst_sat_n),
        .ex_valid_i(s_one), .ex_regwrite_i(s_one), .ex_is_load_i(s_one),
        .ex_dest_i(s_dest), .ex_src_i(s_src), .ex_src_used_i(s_used), .flush_i(1'b0),
        .fwd_sel_o(s_fwd_sel), .stall_o(s_stall), .stall_cycles_o(s_cnt)
    );

    typedef struct {
        string       name;
        bit          sat;
        logic [11:0] sel;
        logic        stl;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [1:0] v, input logic [1:0] rw, input logic [1:0] ld,
                       input logic [4:0] d0, input logic [4:0] d1,
                       input logic [4:0] s0, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [4:0] s3,
                       input logic [3:0] used, input logic fl);
        ex_valid    = v;
        ex_regwrite = rw;
        ex_is_load  = ld;
        ex_dest     = {d1, d0};
        ex_src      = {s3, s2, s1, s0};
        ex_src_used = used;
        flush       = fl;
    endtask

    task automatic idle();
        drv(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 4'b0000, 1'b0);
    endtask

    task automatic drain();
        repeat (2) begin
            tick();
            idle();
        end
    endtask

    task automatic ex(input string name, input logic [2:0] e0, input logic [2:0] e1,
                      input logic [2:0] e2, input logic [2:0] e3,
                      input logic st, input logic [15:0] cnt);
        exp_t e;
        e.name = name; e.sat = 1'b0; e.sel = {e3, e2, e1, e0}; e.stl = st; e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    task automatic exs(input string name, input logic st, input logic [15:0] cnt);
        exp_t e;
        e.name = name; e.sat = 1'b1; e.sel = '0; e.stl = st; e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    // Monitor: outputs are settled by the falling edge, so every pending expectation is checked there.
    initial begin
        exp_t        e;
        logic [11:0] gs;
        logic        gst;
        logic [15:0] gc;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.sat) begin
                    gs = e.sel; gst = s_stall; gc = s_cnt;
                end else begin
                    gs = fwd_sel; gst = stall; gc = stall_cycles;
                end
                checks++;
                if ({gs, gst, gc} !== {e.sel, e.stl, e.cnt}) begin
                    errors++;
                    $display("FAIL %s: got sel=%h stall=%b cnt=%h, want sel=%h stall=%b cnt=%h",
                             e.name, gs, gst, gc, e.sel, e.stl, e.cnt);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        #1;
        ex("rst0", 0, 0, 0, 0, 1'b0, 16'd0);
        tick(); tick();
        rst_n = 1'b1;
        ex("idle", 0, 0, 0, 0, 1'b0, 16'd0);

        // Basic bypass through M, W, then register file
        tick(); drv(2'b01, 2'b01, 2'b00, 5'd5, 5'd0, 0, 0, 0, 0, 4'b0000, 1'b0);
        ex("byp_t", 0, 0, 0, 0, 1'b0, 16'd0);
        tick(); drv(2'b10, 2'b00, 2'b00, 5'd0, 5'd0, 0, 0, 5, 0, 4'b0100, 1'b0);
        ex("byp_m", 0, 0, 1, 0, 1'b0, 16'd0);
        tick(); ex("byp_w", 0, 0, 3, 0, 1'b0, 16'd0);
        tick(); ex("byp_rf", 0, 0, 0, 0, 1'b0, 16'd0);

        // Priority: stage beats lane, then lane within stage
        tick(); drv(2'b01, 2'b01, 2'b00, 5'd7, 5'd0, 0, 0, 0, 0, 4'b0000, 1'b0);
        tick(); drv(2'b10, 2'b10, 2'b00, 5'd0, 5'd7, 0, 0, 0, 0, 4'b0000, 1'b0);
        tick(); drv(2'b01, 2'b00, 2'b00, 5'd0, 5'd0, 0, 7, 0, 0, 4'b0010, 1'b0);
        ex("pri_stage", 0, 2, 0, 0, 1'b0, 16'd0);
        tick(); drv(2'b01, 2'b01, 2'b00, 5'd7, 5'd0, 0, 0, 0, 0, 4'b0000, 1'b0);
        tick(); drv(2'b11, 2'b11, 2'b00, 5'd7, 5'd7, 0, 0, 0, 0, 4'b0000, 1'b0);
        tick(); drv(2'b01, 2'b00, 2'b00, 5'd0, 5'd0, 0, 7, 0, 0, 4'b0010, 1'b0);
        ex("pri_lane", 0, 1, 0, 0, 1'b0, 16'd0);
        drain();

        // Load-use stall, then bubble clears it
        tick(); drv(2'b01, 2'b01, 2'b01, 5'd9, 5'd0, 0, 0, 0, 0, 4'b0000, 1'b0);
        ex("lu_t", 0, 0, 0, 0, 1'b0, 16'd0);
        tick(); drv(2'b01, 2'b00, 2'b00, 5'd0, 5'd0, 9, 0, 0, 0, 4'b0001, 1'b0);
        ex("lu_stall", 1, 0, 0, 0, 1'b1, 16'd0);
        tick(); ex("lu_clear", 3, 0, 0, 0, 1'b0, 16'd1);
        drain();

        // Younger ALU write in the same stage masks the load
        tick(); drv(2'b11, 2'b11, 2'b10, 5'd9, 5'd9, 0, 0, 0, 0, 4'b0000, 1'b0);
        tick(); drv(2'b11, 2'b00, 2'b00, 5'd0, 5'd0, 9, 0, 0, 9, 4'b1001, 1'b0);
        ex("lu_mask", 1, 0, 0, 1, 1'b0, 16'd1);
        drain();

        // Masking: no entry without regwrite or valid; unused operand and dead lane do not stall
        tick(); drv(2'b01, 2'b10, 2'b00, 5'd6, 5'd6, 0, 0, 0, 0, 4'b0000, 1'b0);
        tick(); drv(2'b11, 2'b00, 2'b00, 5'd0, 5'd0, 6, 6, 6, 6, 4'b1111, 1'b0);
        ex("m_norw", 0, 0, 0, 0, 1'b0, 16'd1);
        tick(); drv(2'b11, 2'b11, 2'b00, 5'd0, 5'd0, 0, 0, 0, 0, 4'b0000, 1'b0);
        tick(); drv(2'b11, 2'b00, 2'b00, 5'd0, 5'd0, 0, 0, 0, 0, 4'b1111, 1'b0);
        ex("m_r0", 0, 0, 0, 0, 1'b0, 16'd1);
        tick(); drv(2'b01, 2'b01, 2'b01, 5'd10, 5'd0, 0, 0, 0, 0, 4'b0000, 1'b0);
        tick(); drv(2'b01, 2'b00, 2'b00, 5'd0, 5'd0, 10, 0, 0, 0, 4'b0000, 1'b0);
        ex("m_unused", 1, 0, 0, 0, 1'b0, 16'd1);
        tick(); drv(2'b01, 2'b01, 2'b01, 5'd11, 5'd0, 0, 0, 0, 0, 4'b0000, 1'b0);
        tick(); drv(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 0, 0, 11, 0, 4'b0100, 1'b0);
        ex("m_gate", 0, 0, 1, 0, 1'b0, 16'd1);
        drain();

        // Flush kills the producer
        tick(); drv(2'b01, 2'b01, 2'b00, 5'd4, 5'd0, 0, 0, 0, 0, 4'b0000, 1'b1);
        tick(); drv(2'b01, 2'b00, 2'b00, 5'd0, 5'd0, 4, 0, 0, 0, 4'b0001, 1'b0);
        ex("fl_m", 0, 0, 0, 0, 1'b0, 16'd1);
        tick(); ex("fl_w", 0, 0, 0, 0, 1'b0, 16'd1);

        // Flush together with stall: one bubble, stall still counted
        tick(); drv(2'b01, 2'b01, 2'b01, 5'd12, 5'd0, 0, 0, 0, 0, 4'b0000, 1'b0);
        tick(); drv(2'b01, 2'b00, 2'b00, 5'd0, 5'd0, 12, 0, 0, 0, 4'b0001, 1'b1);
        ex("fs_stall", 1, 0, 0, 0, 1'b1, 16'd1);
        tick(); drv(2'b01, 2'b00, 2'b00, 5'd0, 5'd0, 12, 0, 0, 0, 4'b0001, 1'b0);
        ex("fs_after", 3, 0, 0, 0, 1'b0, 16'd2);
        drain();

        // Asynchronous reset with a full scoreboard
        tick(); drv(2'b11, 2'b11, 2'b00, 5'd5, 5'd5, 0, 0, 0, 0, 4'b0000, 1'b0);
        tick(); drv(2'b11, 2'b11, 2'b00, 5'd5, 5'd5, 5, 5, 5, 5, 4'b1111, 1'b0);
        ex("full", 1, 1, 1, 1, 1'b0, 16'd2);
        tick(); rst_n = 1'b0;
        ex("rst_async", 0, 0, 0, 0, 1'b0, 16'd0);
        tick(); ex("rst_hold", 0, 0, 0, 0, 1'b0, 16'd0);
        tick(); rst_n = 1'b1;
        drv(2'b11, 2'b00, 2'b00, 5'd0, 5'd0, 5, 5, 5, 5, 4'b1111, 1'b0);
        ex("post_rst", 0, 0, 0, 0, 1'b0, 16'd0);
        tick(); ex("post_rst2", 0, 0, 0, 0, 1'b0, 16'd0);
        idle();

        // Counter saturation on the deep-load instance
        tick(); rst_sat_n = 1'b1;
        repeat (800) tick();
        exs("sat_800", 1'b0, 16'd700);
        tick(); exs("sat_801", 1'b1, 16'd700);
        repeat (74896 - 801) tick();
        exs("sat_fffe", 1'b0, 16'hFFFE);
        repeat (8) tick();
        exs("sat_ffff", 1'b0, 16'hFFFF);
        repeat (100) tick();
        exs("sat_hold", 1'b1, 16'hFFFF);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised forwarding and load-use hazard unit for the multi-issue pipeline. It generalises the dual-issue forwarding scheme to LANES issue lanes and STAGES post-execute stages. It holds a registered scoreboard of in-flight destination writes instead of taking per-stage write ports, and adds load-use stall detection and a stall-cycle counter. It sits beside the E stage: it captures the E bundle each cycle and returns per-operand bypass selects to the E-stage operand muxes.

## Interface
- LANES, 2, issue lanes (≥1)
- STAGES, 2, tracked stages after E (stage 0 = M, stage 1 = W, …)
- LOAD_LAT, 1, first stage index at which load data is forwardable (< STAGES)
- SEL_W, $clog2(LANES*STAGES+1), select width (derived)
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- ex_valid  in  LANES  lane holds a live instruction in E
- ex_regwrite  in  LANES  lane writes a register
- ex_is_load  in  LANES  lane is a load
- ex_dest  in  5*LANES  destination register, lane l at [5l+:5]
- ex_src  in  10*LANES  source registers; operand k=2l+{0 rs,1 rt} at [5k+:5]
- ex_src_used  in  2*LANES  operand k is actually read
- flush  in  1  kill the current E bundle
- fwd_sel  out  SEL_W*2*LANES  select for operand k at [SEL_W*k+:SEL_W]
- stall  out  1  load-use hazard; E and earlier stages must hold
- stall_cycles  out  16  saturating count of cycles with stall=1

## Operation
- Scoreboard: STAGES×LANES entries {valid, dest, is_load}. An entry is valid only if the source lane had ex_valid & ex_regwrite & dest≠0.
- Advance every cycle: stage s+1 ← stage s. The entry in stage STAGES-1 retires.
- Stage 0 ← E bundle, unless stall or flush is asserted. In that case stage 0 ← all-invalid bubble.
- Select encoding: 0 = register file. Otherwise k = 1 + s*LANES + l for the entry at stage s, lane l. With the defaults, this gives 1=M lane0, 2=M lane1, 3=W lane0, 4=W lane1.
- Match rule: entry valid and entry dest == operand source. Source r0 never matches.
- Priority: lowest stage index wins (youngest). Within a stage, the lowest lane wins. The issue stage guarantees no same-bundle WAW; the tie-break only makes the result deterministic.
- fwd_sel is combinational from the scoreboard state and ex_src. It is computed regardless of ex_src_used.
- Load-use: stall=1 if any operand with ex_src_used=1 has its winning match on an is_load entry at stage < LOAD_LAT.
  - A younger non-load match masks an older load.
  - stall is gated by ex_valid of the consuming lane.
- stall_cycles increments when stall=1 and saturates at 0xFFFF.
- No FSM beyond the shift pipeline and the counter. All state is reset.

## Timing
- Reset (async, rst_n low):
  - all entries invalid
  - stall_cycles=0
  - consequently fwd_sel=0 and stall=0 immediately, with no clock needed
- Producer in E at cycle t (not stalled or flushed): visible at stage s during cycle t+1+s. Absent from cycle t+1+STAGES.
- stall and fwd_sel have zero-cycle latency, valid in the same cycle as ex_src.
- Stall cycle t:
  - stage 0 at t+1 is a bubble
  - the load moves to stage 1, so the hazard clears for LOAD_LAT=1
  - the stall lasts at most LOAD_LAT cycles per load
- Simultaneous flush and stall: a single bubble. The counter still counts the stall cycle.
- Reset mid-operation discards all in-flight entries. Post-reset forwarding is from the register file only.

## Test plan
- Reset: hold rst_n=0 with a scoreboard full of dest=5 entries, ex_src rs=5. Required: fwd_sel=0, stall=0, stall_cycles=0, asynchronously.
- Basic bypass:
  - cycle t: lane0 ex_regwrite with dest=5
  - t+1: lane1 rs=5 → sel=1
  - t+2 → sel=3
  - t+3 → sel=0
- Priority: stage0 lane1 and stage1 lane0 both dest=7, lane0 rt=7 → sel=2. Add stage0 lane0 dest=7 → sel=1.
- Load-use:
  - cycle t: load lane0 dest=9
  - t+1: lane0 rs=9 used → stall=1
  - t+2: bubble in M → stall=0, sel=3
  - stall_cycles=1
  - Repeat with a younger ALU write to r9 in M → stall=0, sel=1.
- Masking:
  - dest=0 with regwrite → never matched (sel=0)
  - ex_regwrite=0 → no entry
  - load hazard with ex_src_used=0 → stall=0, sel still 1
- Flush: lane0 dest=4 with flush=1 → rs=4 reads sel=0 in the next two cycles. The counter saturates at 0xFFFF under continuous forced stall.
